// File: rtl/recovery_pkg.sv
// Shared encodings, enums and instruction helpers for the procedural
// debug-mode recovery code generator.
package recovery_pkg;

  localparam logic [6:0]  OPC_LOAD      = 7'h03;
  localparam logic [6:0]  OPC_STORE     = 7'h23;
  localparam logic [6:0]  OPC_AUIPC     = 7'h17;
  localparam logic [2:0]  FUNCT3_WORD   = 3'd2;
  localparam logic [4:0]  REG_BASE      = 5'd1;
  localparam logic [11:0] CSR_DSCRATCH0 = 12'h7b2;

  localparam logic [31:0] DRET          = 32'h7b200073;
  localparam logic [31:0] NOP           = 32'h00000013;
  localparam logic [31:0] CSRW_DS0_X1   = {CSR_DSCRATCH0, 5'd1, 3'b001, 5'd0, 7'h73};
  localparam logic [31:0] CSRR_X2_DS0   = {CSR_DSCRATCH0, 5'd0, 3'b010, 5'd2, 7'h73};
  localparam logic [31:0] CSRR_X1_DS0   = {CSR_DSCRATCH0, 5'd0, 3'b010, 5'd1, 7'h73};

  typedef enum logic {MODE_RESTORE = 1'b0, MODE_SAVE = 1'b1} mode_e;
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_e;

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, REG_BASE, FUNCT3_WORD, rd, OPC_LOAD};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, REG_BASE, FUNCT3_WORD, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_auipc(input logic [19:0] hi);
    return {hi, REG_BASE, OPC_AUIPC};
  endfunction

endpackage

// File: rtl/recovery_code_gen_enc.sv
// Combinational stream decoder: word index + mode -> instruction word,
// plus flags for "index inside the stream" and "index is the dret word".
module recovery_insn_enc
  import recovery_pkg::*;
#(
  parameter int          NUM_REGS = 31,
  parameter logic [19:0] CKPT_HI  = 20'h10000
) (
  input  logic [29:0] idx_i,
  input  mode_e       mode_i,
  output logic [31:0] insn_o,
  output logic        last_o,
  output logic        in_range_o
);

  localparam logic [5:0]  N     = 6'(NUM_REGS);
  localparam logic [29:0] LEN_R = 30'(NUM_REGS + 2);
  localparam logic [29:0] LEN_S = 30'(NUM_REGS + 6);

  logic [29:0] len;
  logic [5:0]  sidx;
  logic [5:0]  sidx_p1;

  assign len        = (mode_i == MODE_SAVE) ? LEN_S : LEN_R;
  assign sidx       = idx_i[5:0];
  assign sidx_p1    = sidx + 6'd1;
  assign in_range_o = (idx_i < len);
  assign last_o     = in_range_o && (idx_i == len - 30'd1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    insn_o = NOP;
    if (in_range_o) begin
      if (mode_i == MODE_RESTORE) begin
        if (sidx == 6'd0)      insn_o = enc_auipc(CKPT_HI);
        else if (sidx < N)     insn_o = enc_lw(sidx_p1[4:0], {4'b0, sidx_p1, 2'b00});
        else if (sidx == N)    insn_o = enc_lw(5'd1, 12'd4);
        else                   insn_o = DRET;
      end else begin
        // x1 is parked in dscratch0 first so it can serve as the base pointer.
        if (sidx == 6'd0)              insn_o = CSRW_DS0_X1;
        else if (sidx == 6'd1)         insn_o = enc_auipc(CKPT_HI);
        else if (sidx <= N)            insn_o = enc_sw(sidx[4:0], {4'b0, sidx, 2'b00});
        else if (sidx == N + 6'd1)     insn_o = CSRR_X2_DS0;
        else if (sidx == N + 6'd2)     insn_o = enc_sw(5'd2, 12'd4);
        else if (sidx == N + 6'd3)     insn_o = enc_lw(5'd2, 12'd8);
        else if (sidx == N + 6'd4)     insn_o = CSRR_X1_DS0;
        else                           insn_o = DRET;
      end
    end
  end

endmodule

// File: rtl/recovery_code_gen.sv
// Debug-ROM window that serves the SAVE/RESTORE recovery stream, tracks
// sequence progress and counts completed RESTORE sequences.
module recovery_code_gen
  import recovery_pkg::*;
#(
  parameter logic [31:0] ROM_BASE = 32'h80,
  parameter int          NUM_REGS = 31,
  parameter logic [19:0] CKPT_HI  = 20'h10000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic [31:0]      addr_i,
  input  logic             mode_i,
  output logic [31:0]      rdata_o,
  output logic             rvalid_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] rec_cnt_o
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d, dec_mode;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d, insn;
  logic             rvalid_q, err_q, err_d, done_q, done_d;
  logic [29:0]      idx;
  logic             below, misaligned, is_start, last, in_range, fetch_ok;

  assign below      = (addr_i < ROM_BASE);
  assign misaligned = |addr_i[1:0];
  assign idx        = addr_i[31:2] - ROM_BASE[31:2];
  assign is_start   = !below && (idx == 30'd0);

  // A start fetch re-samples the mode, so it is decoded with the incoming mode.
  assign dec_mode = (state_q == ACTIVE && !is_start) ? mode_q : mode_e'(mode_i);

  recovery_insn_enc #(
    .NUM_REGS (NUM_REGS),
    .CKPT_HI  (CKPT_HI)
  ) u_enc (
    .idx_i      (idx),
    .mode_i     (dec_mode),
    .insn_o     (insn),
    .last_o     (last),
    .in_range_o (in_range)
  );

  assign fetch_ok = req_i && !below && !misaligned && in_range;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    rdata_d = req_i ? (fetch_ok ? insn : NOP) : '0;
    err_d   = req_i && !fetch_ok;
    if (fetch_ok) begin
      if (is_start) begin
        state_d = ACTIVE;
        mode_d  = mode_e'(mode_i);
      end else if (last && state_q == ACTIVE) begin
        state_d = DONE;
        done_d  = 1'b1;
        if (mode_q == MODE_RESTORE && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mode_q   <= MODE_RESTORE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= req_i;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;
  assign err_o     = err_q;
  assign done_o    = done_q;
  assign busy_o    = (state_q == ACTIVE);
  assign rec_cnt_o = cnt_q;

endmodule

// File: tb/tb_recovery_code_gen.sv
// Scoreboard bench: stimulus pushes expected responses from a program-list
// model; a negedge monitor pops and compares whatever the DUT returns.
module tb_recovery_code_gen;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic        mode_i = 1'b0;

  logic [31:0] rdata_o, rdata_s;
  logic        rvalid_o, err_o, busy_o, done_o;
  logic        rvalid_s, err_s, busy_s, done_s;
  logic [15:0] rec_cnt_o;
  logic [1:0]  rec_cnt_s;

  recovery_code_gen dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .mode_i(mode_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .err_o(err_o), .busy_o(busy_o),
    .done_o(done_o), .rec_cnt_o(rec_cnt_o)
  );

  recovery_code_gen #(.CNT_W(2)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .mode_i(mode_i),
    .rdata_o(rdata_s), .rvalid_o(rvalid_s), .err_o(err_s), .busy_o(busy_s),
    .done_o(done_s), .rec_cnt_o(rec_cnt_s)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        done;
    logic        busy;
    logic [31:0] cnt;
    logic [31:0] sat;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] prog_r[$];
  logic [31:0] prog_s[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          m_active = 0;
  bit          m_mode = 0;
  int          m_cnt = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_lw(input int rd, input int imm);
    return 32'((imm << 20) | (1 << 15) | (2 << 12) | (rd << 7) | 3);
  endfunction

  function automatic logic [31:0] m_sw(input int rs2, input int imm);
    return 32'(((imm >> 5) << 25) | (rs2 << 20) | (1 << 15) | (2 << 12) | ((imm & 31) << 7) | 'h23);
  endfunction

  task automatic build_programs();
    logic [31:0] auipc;
    auipc = (32'h10000 << 12) | 32'h97;
    prog_r.push_back(auipc);
    for (int k = 1; k < 31; k++) prog_r.push_back(m_lw(k + 1, 4 * (k + 1)));
    prog_r.push_back(m_lw(1, 4));
    prog_r.push_back(32'h7b200073);
    prog_s.push_back(32'h7b209073);
    prog_s.push_back(auipc);
    for (int k = 2; k <= 31; k++) prog_s.push_back(m_sw(k, 4 * k));
    prog_s.push_back(32'h7b202173);
    prog_s.push_back(m_sw(2, 4));
    prog_s.push_back(m_lw(2, 8));
    prog_s.push_back(32'h7b2020f3);
    prog_s.push_back(32'h7b200073);
  endtask

  task automatic fetch(input logic [31:0] a, input logic m);
    exp_t        e;
    logic [31:0] idx;
    logic        dm;
    logic        bad;
    int          len;
    req_i  = 1'b1;
    addr_i = a;
    mode_i = m;
    bad = (a[1:0] != 2'b00) || (a < 32'h80);
    idx = (a - 32'h80) >> 2;
    dm  = (idx == 0) ? m : (m_active ? m_mode : m);
    len = dm ? prog_s.size() : prog_r.size();
    if (!bad && idx >= 32'(len)) bad = 1'b1;
    e.done = 1'b0;
    if (bad) begin
      e.rdata = 32'h13;
      e.err   = 1'b1;
    end else begin
      e.rdata = dm ? prog_s[idx] : prog_r[idx];
      e.err   = 1'b0;
      if (idx == 0) begin
        m_active = 1;
        m_mode   = m;
      end else if (idx == 32'(len - 1) && m_active) begin
        m_active = 0;
        e.done   = 1'b1;
        if (!m_mode) m_cnt++;
      end
    end
    e.busy = m_active;
    e.cnt  = (m_cnt > 65535) ? 65535 : m_cnt;
    e.sat  = (m_cnt > 3) ? 3 : m_cnt;
    e.due  = cyc + 1;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
  endtask

  task automatic sweep(input logic m, input int from, input int to);
    for (int k = from; k <= to; k++) fetch(32'h80 + 4 * k, m);
  endtask

  task automatic reset_model();
    m_active = 0;
    m_mode   = 0;
    m_cnt    = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk_i);
    check({tag, "_rvalid"}, 32'(rvalid_o), 0);
    check({tag, "_done"}, 32'(done_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_cnt"}, 32'(rec_cnt_o), 0);
    check({tag, "_cnt_sat"}, 32'(rec_cnt_s), 0);
  endtask

  always @(negedge clk_i) begin
    if (rvalid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid: got rvalid=1 expected no response (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rdata", rdata_o, e.rdata);
        check("err", 32'(err_o), 32'(e.err));
        check("done", 32'(done_o), 32'(e.done));
        check("busy", 32'(busy_o), 32'(e.busy));
        check("rec_cnt", 32'(rec_cnt_o), e.cnt);
        check("rec_cnt_sat", 32'(rec_cnt_s), e.sat);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_rvalid: got rvalid=%b expected response %h (t=%0t)",
               rvalid_o, sb[0].rdata, $time);
      void'(sb.pop_front());
    end else if (rst_i === 1'b0) begin
      check("done_without_rvalid", 32'(done_o), 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    build_programs();
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_idle_outputs("reset");

    // RESTORE: full stream plus the first index past the end.
    @(posedge clk_i);
    #1;
    sweep(1'b0, 0, 33);

    // SAVE: full stream; the counter must not move.
    sweep(1'b1, 0, 36);

    // dret index fetched while not in a sequence.
    fetch(32'h100, 1'b0);

    // Mode change mid-sequence is ignored until idx0 is refetched.
    fetch(32'h80, 1'b0);
    fetch(32'h84, 1'b1);
    fetch(32'h88, 1'b1);
    fetch(32'h80, 1'b1);
    fetch(32'h82, 1'b1);
    fetch(32'h7C, 1'b1);
    fetch(32'hFFFF_FFFC, 1'b0);
    sweep(1'b1, 1, 36);

    // Three more RESTORE sequences push the 2-bit counter into saturation.
    for (int s = 0; s < 3; s++) sweep(1'b0, 0, 32);

    // Reset on the cycle after the dret request.
    sweep(1'b0, 0, 32);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    reset_model();
    check_idle_outputs("rst_after_dret");

    // Reset coinciding with a request drops that request.
    @(posedge clk_i);
    #1;
    rst_i  = 1'b1;
    req_i  = 1'b1;
    addr_i = 32'h80;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    req_i = 1'b0;
    check_idle_outputs("rst_with_req");
    @(posedge clk_i);
    #1;

    // Randomised mix of in-order progress, refetches and bad addresses.
    begin
      int          ptr = 0;
      logic        m = 1'b0;
      logic [31:0] a;
      for (int n = 0; n < 600; n++) begin
        int r;
        r = $urandom_range(0, 99);
        if (ptr == 0 && r < 50) m = 1'($urandom_range(0, 1));
        else if (r < 5) m = ~m;
        if (r >= 90) begin
          case ($urandom_range(0, 2))
            0:       a = 32'h7C - 4 * $urandom_range(0, 3);
            1:       a = 32'h80 + 4 * $urandom_range(0, 40) + $urandom_range(1, 3);
            default: a = $urandom;
          endcase
        end else if (r >= 82) begin
          ptr = $urandom_range(0, 40);
          a   = 32'h80 + 4 * ptr;
          ptr = (ptr >= 36) ? 0 : ptr + 1;
        end else begin
          a   = 32'h80 + 4 * ptr;
          ptr = (ptr >= 36) ? 0 : ptr + 1;
        end
        fetch(a, m);
      end
    end

    repeat (3) @(negedge clk_i);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/recovery_code_gen.md
Name: recovery_code_gen

Overview:
Parametrised successor to the fixed recovery ROM in the debug module. It generates the debug-mode recovery instruction stream procedurally. Two modes are supported: SAVE (checkpoint GPRs to memory) and RESTORE (reload GPRs from the checkpoint). The core fetches the stream through the debug ROM address window. The block also tracks sequence progress and counts completed recoveries for the fault-tolerance controller.

Parameters:
ROM_BASE, 32'h80, byte base address of the code window.
NUM_REGS, 31, highest GPR checkpointed (x1..xNUM_REGS); legal range 2..31.
CKPT_HI, 20'h10000, upper immediate of the checkpoint area (auipc x1,CKPT_HI).
CNT_W, 16, width of the recovery counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_i  in  1  fetch request
addr_i  in  32  fetch byte address
mode_i  in  1  0=RESTORE, 1=SAVE; sampled at sequence start
rdata_o  out  32  instruction word
rvalid_o  out  1  rdata_o valid (one cycle after req_i)
err_o  out  1  with rvalid_o: out-of-range or misaligned fetch
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse when the dret word is returned
rec_cnt_o  out  CNT_W  completed RESTORE sequences, saturating

Behaviour:
- Interface: single clock clk_i; rst_i is synchronous, active-high.
- Reset values: rdata_o=0, rvalid_o=0, err_o=0, busy_o=0, done_o=0, rec_cnt_o=0, state=IDLE, mode_q=RESTORE.
- Latency: req_i at cycle N gives rdata_o/rvalid_o/err_o at N+1. There is no backpressure; back-to-back requests are allowed.
- Index calculation: idx=(addr_i-ROM_BASE)>>2, computed on the request cycle.
- Misaligned fetch (addr_i[1:0]!=0), addr_i<ROM_BASE, or idx>=LEN(mode): rdata_o=32'h00000013 (nop), err_o=1.
- Instruction encodings (base register x1):
  - lw rd,imm(x1) = imm<<20|1<<15|2<<12|rd<<7|0x03
  - sw rs2,imm(x1) = imm[11:5]<<25|rs2<<20|1<<15|2<<12|imm[4:0]<<7|0x23
  - auipc x1 = CKPT_HI<<12|0x097
  - dret = 0x7b200073
- RESTORE stream, LEN=NUM_REGS+2:
  - idx0: auipc
  - idx1..NUM_REGS-1: lw x(idx+1),4*(idx+1)(x1)
  - idx NUM_REGS: lw x1,4(x1)
  - idx NUM_REGS+1: dret
- SAVE stream, LEN=NUM_REGS+6:
  - idx0: csrw dscratch0,x1 (0x7b209073)
  - idx1: auipc
  - idx2..NUM_REGS: sw x(idx),4*idx(x1)
  - next: csrr x2,dscratch0 (0x7b202173)
  - next: sw x2,4(x1)
  - next: lw x2,8(x1)
  - next: csrr x1,dscratch0 (0x7b2020f3)
  - last: dret
- The mode used for decode is mode_q while ACTIVE; otherwise it is mode_i.
- FSM (IDLE, ACTIVE, DONE), advanced only on valid (err-free) fetches:
  - IDLE/DONE: fetch idx0 → ACTIVE; mode_q<=mode_i; busy_o=1.
  - ACTIVE: fetch idx0 → restart; mode_q re-sampled; no count.
  - ACTIVE: fetch of the last (dret) index → DONE; done_o pulses in the rvalid cycle; busy_o=0. If mode_q=RESTORE, rec_cnt_o increments, saturating at all-ones.
  - Fetches of non-start, non-last indices never change state. Out-of-order fetches are legal (core may refetch after a branch).
  - Fetch of the dret index while IDLE/DONE: word is returned; no done_o; no count.
- rst_i mid-sequence: state → IDLE and outputs to reset values next cycle. A pending response is dropped (rvalid_o=0).

Decomposition:
- Package recovery_pkg holds:
  - opcode/funct constants (OPC_LOAD, OPC_STORE, OPC_AUIPC, DRET, NOP, CSR_DSCRATCH0 encodings)
  - mode_e {MODE_RESTORE, MODE_SAVE}
  - state_e {IDLE, ACTIVE, DONE}
  - functions enc_lw(rd,imm), enc_sw(rs2,imm)
- One sub-module, recovery_insn_enc: combinational idx+mode → {insn, last, in_range}. The top level holds request registering, the FSM and the counter.

Test Plan:
- Reset, RESTORE mode, fetch 0x80,0x84,0x88 → 0x10000097, 0x0080a103, 0x00c0a183; rvalid_o 1 cycle later; busy_o=1 after the first fetch.
- RESTORE full sweep idx0..32 with NUM_REGS=31:
  - idx31 (0xFC) → 0x0040a083 (lw x1,4(x1))
  - idx32 (0x100) → 0x7b200073; done_o pulses; rec_cnt_o 0→1
  - idx33 (0x104) → 0x00000013, err_o=1
- SAVE mode sweep:
  - idx0 → 0x7b209073
  - idx2 → 0x0020a423 (sw x2,8(x1))
  - last idx36 → dret; done_o=1; rec_cnt_o unchanged
- mode_i toggled from 0 to 1 mid-ACTIVE → decode stays RESTORE. Refetch idx0 → restart in SAVE (idx0 word 0x7b209073), no count.
- Misaligned 0x82 and below-base 0x7C → nop, err_o=1, state unchanged. Back-to-back requests every cycle → one response per cycle.
- rst_i asserted on the cycle after the dret request → rvalid_o=0, done_o=0, rec_cnt_o=0, busy_o=0. With CNT_W=2, four RESTORE sequences → rec_cnt_o saturates at 3.
